control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port i_start, input, 1 bit: level; run enable from the user interface.
REQ-004 SHALL have port i_ir_opcode, input, 8 bits: opcode delivered by the IR over its C14 path.
REQ-005 SHALL have port i_flags, input, 5 bits: ALU flags {MF,NF,OF,CF,ZF}, bit0 = ZF (zero), bit3 = NF (negative).
REQ-006 SHALL have port o_ctrl, output, 16 bits: register-transfer controls C15..C0, bit n = Cn.
REQ-007 SHALL have port o_alu_op, output, 4 bits: C19..C16; bit3 = ALU enable, bits2:0 = operation.
REQ-008 SHALL have port o_mar_increment, output, 1 bit: C22.
REQ-009 SHALL have port o_halt, output, 1 bit: C23; high while halted.
REQ-010 SHALL have port o_cpu_start, output, 1 bit: gates the first PC->MAR transfer.
REQ-011 SHALL have port o_state, output, 3 bits: current macro-state, for debug and the user interface.

Function
REQ-012 SHALL implement macro-states IDLE=0, FETCH=1, DECODE=2, EXEC=3 and HALT=4.
REQ-013 SHALL stay in IDLE with all controls 0 until i_start=1 is sampled, then enter FETCH on the next edge.
REQ-014 SHALL drive o_cpu_start=1 in every state except IDLE.
REQ-015 SHALL sequence micro-steps with a 6-bit control address register (CAR); every state after IDLE lasts an integer number of cycles, one micro-word per cycle.
REQ-016 SHALL register all outputs, so each micro-word appears on the outputs during the cycle after CAR selects it.
REQ-017 SHALL run FETCH as three micro-words: F0 = C2, F1 = C5, F2 = C4.
REQ-018 SHALL run DECODE as one micro-word, D0 = C14, and latch i_ir_opcode into an internal opcode register at the end of D0.
REQ-019 SHALL, in DECODE, map the opcode to an EXEC entry CAR: 01 STORE, 02 LOAD, 03 ADD, 04 SUB, 05 JMPGEZ, 06 JMP, 07 HALT, 08 MPY, 0A AND, 0B OR, 0C NOT.
REQ-020 SHALL map any unlisted opcode to a single no-op micro-word and then return to FETCH.
REQ-021 SHALL run EXEC micro-words as follows.
- All operand opcodes first issue E0 = C15|C8, placing the IR address on MAR.
- LOAD: C5, then C11.
- STORE: C12, then C13.
- ADD/SUB/AND/OR/MPY: C5, then C6|C7 with alu_op = 1_xxx (xxx = 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MPY), then C9 (C9|C10 for MPY).
- NOT: skips E0 and issues one micro-word C7 with alu_op = 1_101, then C9.
- JMP: C15|C3.
- JMPGEZ: C15|C3 only when NF=0; otherwise a no-op.
REQ-022 SHALL sample i_flags for JMPGEZ in the EXEC cycle that issues the jump word, not at decode.
REQ-023 SHALL return from the last EXEC micro-word to F0, so instructions run back-to-back with no gap cycle.
REQ-024 SHALL, for opcode 07 HALT, enter HALT after D0, drive o_halt=1 with all other controls 0, and stay there until reset.
REQ-025 SHALL, if i_start falls mid-instruction, complete the instruction and then return to IDLE instead of F0.
REQ-026 SHALL never assert o_mar_increment and C2 or C8 in the same cycle.
REQ-027 SHALL never assert C5 and C13 in the same cycle.
REQ-028 SHALL hold the CAR at its current value if it would exceed 63, and force HALT on that condition (fail-safe).

Reset
REQ-029 SHALL, while i_rst=1, immediately force state=IDLE, CAR=0, opcode register=0 and every output to 0, regardless of the clock.
REQ-030 SHALL treat i_rst asserted mid-instruction as a clean abort, with no partial micro-word emitted after release.
REQ-031 SHALL, after release, perform its first FETCH only on a rising edge that samples i_start=1.

Structure
REQ-032 SHALL place the opcode constants, macro-state encodings, ALU op codes and C-bit index constants in a shared package named cpu_pkg.
REQ-033 SHALL implement the micro-program as a combinational sub-module control_memory that maps CAR to a 24-bit micro-word {C23..C0} plus next-address and branch fields.
REQ-034 SHALL keep the sequencer, opcode mapping and flag test in control_unit itself.

Verification
REQ-035 SHALL cover reset with i_start=0 held for 10 cycles -> o_ctrl=0, o_state=IDLE, o_cpu_start=0 throughout.
REQ-036 SHALL cover i_start=1 followed by opcode 02 (LOAD) -> o_ctrl sequence 0x0004, 0x0020, 0x0010, 0x4000, 0x8100, 0x0020, 0x0800, then 0x0004 again.
REQ-037 SHALL cover opcode 03 (ADD) -> the EXEC ALU word is o_ctrl=0x00C0 with o_alu_op=4'b1000, followed by o_ctrl=0x0200.
REQ-038 SHALL cover opcode 05 (JMPGEZ) -> with i_flags=5'b01000 no C3 is asserted; with i_flags=5'b00000 o_ctrl=0x8008 is asserted once.
REQ-039 SHALL cover opcode 07 (HALT) -> o_halt=1 from the cycle after D0 onward, o_ctrl=0 thereafter, and it persists with i_start toggling.
REQ-040 SHALL cover i_rst pulsed during EXEC of ADD -> outputs go to 0 without waiting for a clock edge, and a restart fetch shows 0x0004 first.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the microprogrammed CPU control unit: macro-states,
// opcodes, ALU operations, control-bit indices and the micro-address map.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    BR_NEXT     = 2'd0,
    BR_JUMP     = 2'd1,
    BR_DISPATCH = 2'd2,
    BR_END      = 2'd3
  } branch_t;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MPY    = 8'h08;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_NOT    = 8'h0C;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MPY = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;

  localparam int C2        = 2;
  localparam int C3        = 3;
  localparam int C4        = 4;
  localparam int C5        = 5;
  localparam int C6        = 6;
  localparam int C7        = 7;
  localparam int C8        = 8;
  localparam int C9        = 9;
  localparam int C10       = 10;
  localparam int C11       = 11;
  localparam int C12       = 12;
  localparam int C13       = 13;
  localparam int C14       = 14;
  localparam int C15       = 15;
  localparam int C_MAR_INC = 22;
  localparam int C_HALT    = 23;

  localparam int FLAG_NF = 3;

  // Micro-address map: each operand routine is a contiguous run ending in BR_END.
  localparam logic [5:0] A_F0     = 6'd0;
  localparam logic [5:0] A_F1     = 6'd1;
  localparam logic [5:0] A_F2     = 6'd2;
  localparam logic [5:0] A_D0     = 6'd3;
  localparam logic [5:0] A_HALT   = 6'd4;
  localparam logic [5:0] A_NOP    = 6'd5;
  localparam logic [5:0] A_JUMP   = 6'd6;
  localparam logic [5:0] A_NOT0   = 6'd7;
  localparam logic [5:0] A_NOT1   = 6'd8;
  localparam logic [5:0] A_LOAD0  = 6'd10;
  localparam logic [5:0] A_LOAD1  = 6'd11;
  localparam logic [5:0] A_LOAD2  = 6'd12;
  localparam logic [5:0] A_STORE0 = 6'd13;
  localparam logic [5:0] A_STORE1 = 6'd14;
  localparam logic [5:0] A_STORE2 = 6'd15;
  localparam logic [5:0] A_ADD0   = 6'd16;
  localparam logic [5:0] A_ADD1   = 6'd17;
  localparam logic [5:0] A_ADD2   = 6'd18;
  localparam logic [5:0] A_ADD3   = 6'd19;
  localparam logic [5:0] A_SUB0   = 6'd20;
  localparam logic [5:0] A_SUB1   = 6'd21;
  localparam logic [5:0] A_SUB2   = 6'd22;
  localparam logic [5:0] A_SUB3   = 6'd23;
  localparam logic [5:0] A_AND0   = 6'd24;
  localparam logic [5:0] A_AND1   = 6'd25;
  localparam logic [5:0] A_AND2   = 6'd26;
  localparam logic [5:0] A_AND3   = 6'd27;
  localparam logic [5:0] A_OR0    = 6'd28;
  localparam logic [5:0] A_OR1    = 6'd29;
  localparam logic [5:0] A_OR2    = 6'd30;
  localparam logic [5:0] A_OR3    = 6'd31;
  localparam logic [5:0] A_MPY0   = 6'd32;
  localparam logic [5:0] A_MPY1   = 6'd33;
  localparam logic [5:0] A_MPY2   = 6'd34;
  localparam logic [5:0] A_MPY3   = 6'd35;

  function automatic logic [23:0] cbit(input int n);
    cbit = 24'd1 << n;
  endfunction

  // ALU field occupies C19..C16: enable bit on top of the 3-bit operation.
  function automatic logic [23:0] alu_word(input logic [2:0] op);
    alu_word = {4'b0000, 1'b1, op, 16'h0000};
  endfunction

endpackage

// File: rtl/control_memory.sv
// Combinational micro-program store: maps the control address register to a
// 24-bit micro-word {C23..C0} plus sequencing fields.
module control_memory
  import cpu_pkg::*;
(
  input  logic [5:0]  car,
  output logic [23:0] word,
  output logic [5:0]  next_addr,
  output logic [1:0]  branch,
  output logic [2:0]  next_state
);

  always_comb begin
    word       = '0;
    next_addr  = '0;
    branch     = BR_NEXT;
    next_state = ST_EXEC;
    case (car)
      A_F0: begin
        word       = cbit(C2);
        next_state = ST_FETCH;
      end
      A_F1: begin
        word       = cbit(C5);
        next_state = ST_FETCH;
      end
      A_F2: begin
        word       = cbit(C4);
        next_state = ST_DECODE;
      end
      A_D0: begin
        word   = cbit(C14);
        branch = BR_DISPATCH;
      end
      A_HALT: begin
        word       = cbit(C_HALT);
        branch     = BR_JUMP;
        next_addr  = A_HALT;
        next_state = ST_HALT;
      end
      A_NOP: begin
        branch = BR_END;
      end
      // Shared by JMP and JMPGEZ; the sequencer suppresses it for a failed JMPGEZ.
      A_JUMP: begin
        word   = cbit(C15) | cbit(C3);
        branch = BR_END;
      end
      A_NOT0: word = cbit(C7) | alu_word(ALU_NOT);
      A_NOT1: begin
        word   = cbit(C9);
        branch = BR_END;
      end
      A_LOAD0, A_STORE0, A_ADD0, A_SUB0, A_AND0, A_OR0, A_MPY0:
        word = cbit(C15) | cbit(C8);
      A_LOAD1, A_ADD1, A_SUB1, A_AND1, A_OR1, A_MPY1:
        word = cbit(C5);
      A_LOAD2: begin
        word   = cbit(C11);
        branch = BR_END;
      end
      A_STORE1: word = cbit(C12);
      A_STORE2: begin
        word   = cbit(C13);
        branch = BR_END;
      end
      A_ADD2: word = cbit(C6) | cbit(C7) | alu_word(ALU_ADD);
      A_SUB2: word = cbit(C6) | cbit(C7) | alu_word(ALU_SUB);
      A_AND2: word = cbit(C6) | cbit(C7) | alu_word(ALU_AND);
      A_OR2:  word = cbit(C6) | cbit(C7) | alu_word(ALU_OR);
      A_MPY2: word = cbit(C6) | cbit(C7) | alu_word(ALU_MPY);
      A_ADD3, A_SUB3, A_AND3, A_OR3: begin
        word   = cbit(C9);
        branch = BR_END;
      end
      A_MPY3: begin
        word   = cbit(C9) | cbit(C10);
        branch = BR_END;
      end
      // Unmapped addresses are treated as a halt so a corrupted CAR stops safely.
      default: begin
        word       = cbit(C_HALT);
        branch     = BR_JUMP;
        next_addr  = A_HALT;
        next_state = ST_HALT;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microprogrammed CPU control unit: macro-state sequencer, CAR, opcode dispatch
// and JMPGEZ flag test around the control_memory micro-program.
module control_unit
  import cpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_ir_opcode,
  input  logic [4:0]  i_flags,
  output logic [15:0] o_ctrl,
  output logic [3:0]  o_alu_op,
  output logic        o_mar_increment,
  output logic        o_halt,
  output logic        o_cpu_start,
  output logic [2:0]  o_state
);

  state_t      state, state_next;
  logic [5:0]  car, car_next;
  logic [6:0]  car_inc;
  logic [7:0]  opcode_q;
  logic [23:0] mem_word, out_word, ctrl_q;
  logic [5:0]  mem_next_addr;
  logic [1:0]  mem_branch;
  logic [2:0]  mem_next_state;
  logic        cpu_start_q;
  logic        jump_taken;
  logic        unused_bits;

  control_memory u_control_memory (
    .car        (car),
    .word       (mem_word),
    .next_addr  (mem_next_addr),
    .branch     (mem_branch),
    .next_state (mem_next_state)
  );

  function automatic logic [5:0] entry_for(input logic [7:0] op);
    case (op)
      OP_STORE:          entry_for = A_STORE0;
      OP_LOAD:           entry_for = A_LOAD0;
      OP_ADD:            entry_for = A_ADD0;
      OP_SUB:            entry_for = A_SUB0;
      OP_JMPGEZ, OP_JMP: entry_for = A_JUMP;
      OP_HALT:           entry_for = A_HALT;
      OP_MPY:            entry_for = A_MPY0;
      OP_AND:            entry_for = A_AND0;
      OP_OR:             entry_for = A_OR0;
      OP_NOT:            entry_for = A_NOT0;
      default:           entry_for = A_NOP;
    endcase
  endfunction

  assign car_inc    = {1'b0, car} + 7'd1;
  assign jump_taken = !((opcode_q == OP_JMPGEZ) && i_flags[FLAG_NF]);

  always_comb begin
    state_next = state;
    car_next   = car;
    out_word   = '0;
    case (state)
      ST_IDLE: begin
        car_next = A_F0;
        if (i_start) state_next = ST_FETCH;
      end
      ST_HALT: out_word = cbit(C_HALT);
      default: begin
        out_word = mem_word;
        if (car == A_JUMP && !jump_taken) out_word = '0;
        case (branch_t'(mem_branch))
          BR_NEXT: begin
            // Running off the end of the store freezes the CAR and halts.
            if (car_inc[6]) begin
              state_next = ST_HALT;
            end else begin
              car_next   = car_inc[5:0];
              state_next = state_t'(mem_next_state);
            end
          end
          BR_JUMP: begin
            car_next   = mem_next_addr;
            state_next = state_t'(mem_next_state);
          end
          BR_DISPATCH: begin
            car_next   = entry_for(i_ir_opcode);
            state_next = (i_ir_opcode == OP_HALT) ? ST_HALT : ST_EXEC;
          end
          BR_END: begin
            car_next   = A_F0;
            state_next = i_start ? ST_FETCH : ST_IDLE;
          end
          default: state_next = ST_HALT;
        endcase
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      car         <= '0;
      opcode_q    <= '0;
      ctrl_q      <= '0;
      cpu_start_q <= 1'b0;
    end else begin
      state       <= state_next;
      car         <= car_next;
      ctrl_q      <= out_word;
      cpu_start_q <= (state_next != ST_IDLE);
      if (state == ST_DECODE && branch_t'(mem_branch) == BR_DISPATCH)
        opcode_q <= i_ir_opcode;
    end
  end

  assign o_ctrl          = ctrl_q[15:0];
  assign o_alu_op        = ctrl_q[19:16];
  assign o_mar_increment = ctrl_q[C_MAR_INC];
  assign o_halt          = ctrl_q[C_HALT];
  assign o_cpu_start     = cpu_start_q;
  assign o_state         = state;

  assign unused_bits = ^{i_flags[4], i_flags[2:0], ctrl_q[21:20]};

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: expected micro-words are queued per
// instruction and popped against the registered outputs every cycle.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  opcode;
  logic [4:0]  flags;
  logic [15:0] ctrl;
  logic [3:0]  alu_op;
  logic        mar_inc;
  logic        halt;
  logic        cpu_start;
  logic [2:0]  state;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [3:0]  alu;
    logic        halt;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  control_unit dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_ir_opcode     (opcode),
    .i_flags         (flags),
    .o_ctrl          (ctrl),
    .o_alu_op        (alu_op),
    .o_mar_increment (mar_inc),
    .o_halt          (halt),
    .o_cpu_start     (cpu_start),
    .o_state         (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_word(input logic [15:0] c, input logic [3:0] a, input logic h);
    exp_t e;
    e.ctrl = c;
    e.alu  = a;
    e.halt = h;
    sb.push_back(e);
  endtask

  // Reference micro-word sequence for one instruction (fetch, decode, execute).
  task automatic push_instr(input logic [7:0] op, input logic nf);
    logic [2:0] aop;
    push_word(16'h0004, 4'b0000, 1'b0);
    push_word(16'h0020, 4'b0000, 1'b0);
    push_word(16'h0010, 4'b0000, 1'b0);
    push_word(16'h4000, 4'b0000, 1'b0);
    case (op)
      8'h01: begin
        push_word(16'h8100, 4'b0000, 1'b0);
        push_word(16'h1000, 4'b0000, 1'b0);
        push_word(16'h2000, 4'b0000, 1'b0);
      end
      8'h02: begin
        push_word(16'h8100, 4'b0000, 1'b0);
        push_word(16'h0020, 4'b0000, 1'b0);
        push_word(16'h0800, 4'b0000, 1'b0);
      end
      8'h03, 8'h04, 8'h08, 8'h0A, 8'h0B: begin
        case (op)
          8'h03:   aop = 3'b000;
          8'h04:   aop = 3'b001;
          8'h0A:   aop = 3'b010;
          8'h0B:   aop = 3'b011;
          default: aop = 3'b100;
        endcase
        push_word(16'h8100, 4'b0000, 1'b0);
        push_word(16'h0020, 4'b0000, 1'b0);
        push_word(16'h00C0, {1'b1, aop}, 1'b0);
        push_word((op == 8'h08) ? 16'h0600 : 16'h0200, 4'b0000, 1'b0);
      end
      8'h05: push_word(nf ? 16'h0000 : 16'h8008, 4'b0000, 1'b0);
      8'h06: push_word(16'h8008, 4'b0000, 1'b0);
      8'h07: ;
      8'h0C: begin
        push_word(16'h0080, 4'b1101, 1'b0);
        push_word(16'h0200, 4'b0000, 1'b0);
      end
      default: push_word(16'h0000, 4'b0000, 1'b0);
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    start  = 1'b0;
    flags  = 5'b00000;
    opcode = 8'h00;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_first_word(output bit found);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (ctrl !== 16'h0000) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    start  = 1'b0;
    flags  = 5'b00000;
    opcode = 8'h00;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ctrl !== 16'h0 || alu_op !== 4'h0 || halt !== 1'b0 || mar_inc !== 1'b0 ||
        state !== 3'd0 || cpu_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: ctrl=%h alu=%b halt=%b inc=%b state=%0d cpu_start=%b, want all 0",
               ctrl, alu_op, halt, mar_inc, state, cpu_start);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ctrl !== 16'h0 || state !== 3'd0 || cpu_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: ctrl=%h state=%0d cpu_start=%b, want 0000/0/0",
                 i, ctrl, state, cpu_start);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] prog [11];
    exp_t e;
    int   n;
    bit   found;
    prog = '{8'h02, 8'h01, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h08, 8'h0C, 8'h06, 8'hFF, 8'h02};
    do_reset();
    opcode = prog[0];
    start  = 1'b1;
    wait_first_word(found);
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL b2b_first_fetch: got ctrl=%h, want 0004 within 6 cycles", ctrl);
    end
    for (int i = 0; i < 10; i++) begin
      push_instr(prog[i], 1'b0);
      n = sb.size();
      for (int j = 0; j < n; j++) begin
        e = sb.pop_front();
        checks++;
        if (ctrl !== e.ctrl || alu_op !== e.alu || halt !== e.halt || mar_inc !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b op=%h step %0d: got ctrl=%h alu=%b halt=%b inc=%b, want ctrl=%h alu=%b halt=%b inc=0",
                   prog[i], j, ctrl, alu_op, halt, mar_inc, e.ctrl, e.alu, e.halt);
        end
        if (j == 3) opcode = prog[i+1];
        @(negedge clk);
      end
    end
    checks++;
    if (ctrl !== 16'h0004 || cpu_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_refetch: got ctrl=%h cpu_start=%b, want 0004/1", ctrl, cpu_start);
    end
  endtask

  // Flags change after decode so the jump decision must use the execute-time NF.
  task automatic test_jmpgez();
    logic nf_seq [3];
    exp_t e;
    int   n;
    bit   found;
    nf_seq = '{1'b1, 1'b0, 1'b1};
    do_reset();
    opcode = 8'h05;
    flags  = 5'b01000;
    start  = 1'b1;
    wait_first_word(found);
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL jmpgez_first_fetch: got ctrl=%h, want 0004 within 6 cycles", ctrl);
    end
    for (int i = 0; i < 3; i++) begin
      push_instr(8'h05, nf_seq[i]);
      n = sb.size();
      for (int j = 0; j < n; j++) begin
        e = sb.pop_front();
        checks++;
        if (ctrl !== e.ctrl || alu_op !== e.alu || halt !== e.halt || mar_inc !== 1'b0) begin
          errors++;
          $display("[TB] FAIL jmpgez instr %0d step %0d: got ctrl=%h alu=%b halt=%b, want ctrl=%h alu=%b halt=%b",
                   i, j, ctrl, alu_op, halt, e.ctrl, e.alu, e.halt);
        end
        if (j == 3) flags = nf_seq[i] ? 5'b01000 : 5'b00000;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    int   n;
    bit   found;
    do_reset();
    opcode = 8'h07;
    start  = 1'b1;
    wait_first_word(found);
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL halt_first_fetch: got ctrl=%h, want 0004 within 6 cycles", ctrl);
    end
    push_instr(8'h07, 1'b0);
    for (int k = 0; k < 8; k++) push_word(16'h0000, 4'b0000, 1'b1);
    n = sb.size();
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      checks++;
      if (ctrl !== e.ctrl || alu_op !== e.alu || halt !== e.halt || mar_inc !== 1'b0) begin
        errors++;
        $display("[TB] FAIL halt step %0d: got ctrl=%h alu=%b halt=%b inc=%b, want ctrl=%h alu=%b halt=%b inc=0",
                 j, ctrl, alu_op, halt, mar_inc, e.ctrl, e.alu, e.halt);
      end
      if (j >= 4) start = ~start;
      @(negedge clk);
    end
    checks++;
    if (state !== 3'd4 || cpu_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL halt_state: got state=%0d cpu_start=%b, want 4/1", state, cpu_start);
    end
  endtask

  task automatic test_stop();
    exp_t e;
    int   n;
    bit   found;
    do_reset();
    opcode = 8'h03;
    start  = 1'b1;
    wait_first_word(found);
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL stop_first_fetch: got ctrl=%h, want 0004 within 6 cycles", ctrl);
    end
    push_instr(8'h03, 1'b0);
    n = sb.size();
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      checks++;
      if (ctrl !== e.ctrl || alu_op !== e.alu || halt !== e.halt) begin
        errors++;
        $display("[TB] FAIL stop step %0d: got ctrl=%h alu=%b halt=%b, want ctrl=%h alu=%b halt=%b",
                 j, ctrl, alu_op, halt, e.ctrl, e.alu, e.halt);
      end
      if (j == 3) start = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctrl !== 16'h0 || state !== 3'd0 || cpu_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stop_idle cycle %0d: ctrl=%h state=%0d cpu_start=%b, want 0000/0/0",
                 i, ctrl, state, cpu_start);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    bit   found;
    do_reset();
    opcode = 8'h03;
    start  = 1'b1;
    wait_first_word(found);
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL abort_first_fetch: got ctrl=%h, want 0004 within 6 cycles", ctrl);
    end
    push_instr(8'h03, 1'b0);
    for (int j = 0; j < 7; j++) begin
      e = sb.pop_front();
      checks++;
      if (ctrl !== e.ctrl || alu_op !== e.alu) begin
        errors++;
        $display("[TB] FAIL abort step %0d: got ctrl=%h alu=%b, want ctrl=%h alu=%b",
                 j, ctrl, alu_op, e.ctrl, e.alu);
      end
      if (j < 6) @(negedge clk);
    end
    sb.delete();
    #1 rst = 1'b1;
    start = 1'b0;
    #1;
    checks++;
    if (ctrl !== 16'h0 || alu_op !== 4'h0 || halt !== 1'b0 || state !== 3'd0 || cpu_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_async: ctrl=%h alu=%b halt=%b state=%0d cpu_start=%b, want all 0 before clock",
               ctrl, alu_op, halt, state, cpu_start);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (ctrl !== 16'h0 || state !== 3'd0) begin
        errors++;
        $display("[TB] FAIL abort_idle: ctrl=%h state=%0d, want 0000/0", ctrl, state);
      end
    end
    start = 1'b1;
    wait_first_word(found);
    checks++;
    if (!found || ctrl !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL abort_restart: got ctrl=%h, want 0004 as first word", ctrl);
    end
    @(negedge clk);
    checks++;
    if (ctrl !== 16'h0020) begin
      errors++;
      $display("[TB] FAIL abort_restart_f1: got ctrl=%h, want 0020", ctrl);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_jmpgez();
    test_halt();
    test_stop();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
